regs_wb_arbiter: RTL and testbench
==================================

# regs_wb_arbiter

Write-back arbiter and pending-write scoreboard for the shared 32x32 register file of the multi-cycle MIPS core. Three write-back sources (ALU, load unit, multiply/divide unit) compete for the register file's single write port. The block grants one per cycle in round-robin order and drives the port (`reg_W_addr`, `wdata`, `reg_we`) from a registered stage. It also tracks destination registers claimed at issue but not yet written, so decode can stall on read-after-write hazards.

## Interface
- `ADDR_W`, 5: register address width.
- `DATA_W`, 32: register data width.

- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `req`  in  3  write-back request per source: bit0 ALU, bit1 load, bit2 MDU.
- `req_addr0`/`req_addr1`/`req_addr2`  in  ADDR_W  destination register per source.
- `req_data0`/`req_data1`/`req_data2`  in  DATA_W  write data per source.
- `gnt`  out  3  one-hot combinational grant; the source is accepted at the edge where `gnt` is high.
- `reg_W_addr`  out  ADDR_W  register-file write address (registered).
- `wdata`  out  DATA_W  register-file write data (registered).
- `reg_we`  out  1  register-file write enable (registered).
- `claim_valid`  in  1  issue stage reserves a destination register this cycle.
- `claim_addr`  in  ADDR_W  register being reserved.
- `chk_addr_A`, `chk_addr_B`  in  ADDR_W  decode read addresses to check.
- `busy_A`, `busy_B`  out  1  combinational: the checked register has a pending write.
- `busy_vec`  out  32  scoreboard bitmap; bit 0 is always 0.
- `claim_err`  out  1  registered one-cycle pulse: a claim hit an already-busy register.

## Operation

**Handshake**
- A source holds `req[i]`, `req_addr_i` and `req_data_i` stable until it samples `gnt[i]=1`.
- The source may drop `req[i]` in the cycle after the grant or issue a new request immediately.

**Arbitration**
- `rr_ptr` is 2 bits with legal values 0..2 and resets to 0.
- The grant goes to the first asserted `req` bit scanning `rr_ptr`, `rr_ptr+1`, `rr_ptr+2`, all mod 3.
- `gnt` is all-zero when `req=0` or `rst=0`.
- On a grant to index i, `rr_ptr <= (i+1) mod 3`. With no grant, `rr_ptr` holds.

**Write stage**
- On a granted edge, the write-stage registers take `reg_W_addr <= req_addr_i` and `wdata <= req_data_i`.
- `reg_we <= (req_addr_i != 0)`.
- With no grant, `reg_we <= 0`; `reg_W_addr` and `wdata` hold.
- A grant to address 0 is accepted (the source is released) but produces no write.

**Scoreboard**
- On `claim_valid` with `claim_addr != 0`: `busy_vec[claim_addr] <= 1`.
- On `reg_we=1`: `busy_vec[reg_W_addr] <= 0`. The bit clears at the same edge the register file commits the data.
- Claim and clear of the same address on the same edge: claim wins, and the bit stays 1.
- A claim of an address whose bit is already 1: `claim_err <= 1` for one cycle and the bit stays 1. There is no counting; upstream must stall rather than double-claim.
- A claim of address 0 is ignored and produces no error.
- `busy_A = busy_vec[chk_addr_A]` and `busy_B = busy_vec[chk_addr_B]`. Address 0 therefore always reads 0.
- A write-back without a prior claim is legal and clears nothing extra.

**Reset** (`rst=0` at an edge)
- `rr_ptr=0`, `reg_W_addr=0`, `wdata=0`, `reg_we=0`, `busy_vec=0`, `claim_err=0`.
- `gnt` is forced to 0 while `rst=0`.
- A request pending during reset is not accepted. The source must keep requesting after reset.

## Timing
- Cycle N: `req[i]` and `gnt[i]` high; acceptance at the end of N.
- Cycle N+1: `reg_we=1` and the register file writes at the end of N+1.
- The busy bit reads 0 from cycle N+2, the first cycle in which a read of the register returns the new data.
- Sustained throughput is one write per cycle.
- Worst-case wait for a continuously requesting source is 2 cycles.
- A claim at the end of cycle C is visible on `busy_*` and `busy_vec` in cycle C+1.
- `claim_err` is high during C+1 only.

## Test plan
- **Reset.** Drive `rst=0` for 2 cycles with `req=3'b111`. Required: `gnt=0`, `reg_we=0`, `busy_vec=0`, `claim_err=0`. After release: first `gnt=3'b001`.
- **Round-robin.** Hold `req=3'b111` for 6 cycles with addresses 1, 2, 3. Required: `gnt` sequence 001, 010, 100, 001, 010, 100. `reg_W_addr` follows one cycle later: 1, 2, 3, 1, 2, 3, each with `reg_we=1`.
- **Skip idle sources.** `rr_ptr=1` (after an ALU grant), then `req=3'b101`. Required: `gnt=100` next, then `001`.
- **Scoreboard lifecycle.** Claim r5, check `chk_addr_A=5`. Then load requests r5 with data `0xDEADBEEF`. Required: `busy_A=1` from the cycle after the claim until the cycle after `reg_we`. `busy_A=0` two cycles after `gnt`. `wdata=0xDEADBEEF`.
- **Simultaneous events.**
  - `reg_we` for r7 on the same edge as a claim of r7: required `busy_vec[7]` stays 1 and `claim_err=0`.
  - Second claim of r7 while busy: required `claim_err` pulses once.
- **Address zero.** A grant with `req_addr1=0`, and a claim of r0. Required: `gnt[1]=1`, `reg_we=0` next cycle, `busy_vec[0]=0`, `busy_A=0` for `chk_addr_A=0`, `claim_err=0`.

Source files
------------

// File: rtl/regs_wb_arbiter.sv
// Write-back arbiter for the shared register file: round-robin grant of three
// sources onto a registered write port, plus a pending-write scoreboard for RAW stalls.
module regs_wb_arbiter #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [2:0]               req,
   input  logic [ADDR_W-1:0]        req_addr0,
   input  logic [ADDR_W-1:0]        req_addr1,
   input  logic [ADDR_W-1:0]        req_addr2,
   input  logic [DATA_W-1:0]        req_data0,
   input  logic [DATA_W-1:0]        req_data1,
   input  logic [DATA_W-1:0]        req_data2,
   output logic [2:0]               gnt,
   output logic [ADDR_W-1:0]        reg_W_addr,
   output logic [DATA_W-1:0]        wdata,
   output logic                     reg_we,
   input  logic                     claim_valid,
   input  logic [ADDR_W-1:0]        claim_addr,
   input  logic [ADDR_W-1:0]        chk_addr_A,
   input  logic [ADDR_W-1:0]        chk_addr_B,
   output logic                     busy_A,
   output logic                     busy_B,
   output logic [(1<<ADDR_W)-1:0]   busy_vec,
   output logic                     claim_err
);

   localparam int NREG = 1 << ADDR_W;
   localparam logic [NREG-1:0] ONE_HOT0 = {{(NREG-1){1'b0}}, 1'b1};

   logic [1:0]        rr_ptr_q, rr_ptr_d;
   logic [ADDR_W-1:0] reg_W_addr_q, reg_W_addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              reg_we_q, reg_we_d;
   logic [NREG-1:0]   busy_vec_q, busy_vec_d;
   logic              claim_err_q, claim_err_d;

   logic [2:0]        gnt_s;
   logic [ADDR_W-1:0] sel_addr_s;
   logic [DATA_W-1:0] sel_data_s;
   logic [NREG-1:0]   clr_mask_s, set_mask_s;
   logic              claim_ok_s, clr_hit_s;

   // First requester at or after ptr, scanning modulo 3.
   function automatic logic [2:0] rr_pick(input logic [2:0] r, input logic [1:0] ptr);
      logic [2:0] g;
      g = 3'b000;
      case (ptr)
         2'd1: begin
            if (r[1]) g = 3'b010; else if (r[2]) g = 3'b100; else if (r[0]) g = 3'b001; else g = 3'b000;
         end
         2'd2: begin
            if (r[2]) g = 3'b100; else if (r[0]) g = 3'b001; else if (r[1]) g = 3'b010; else g = 3'b000;
         end
         default: begin
            if (r[0]) g = 3'b001; else if (r[1]) g = 3'b010; else if (r[2]) g = 3'b100; else g = 3'b000;
         end
      endcase
      return g;
   endfunction

   // Grant selection, write-stage next state and pointer advance.
   always_comb begin
      gnt_s        = rst ? rr_pick(req, rr_ptr_q) : 3'b000;
      sel_addr_s   = req_addr0;
      sel_data_s   = req_data0;
      rr_ptr_d     = rr_ptr_q;
      reg_W_addr_d = reg_W_addr_q;
      wdata_d      = wdata_q;
      reg_we_d     = 1'b0;
      case (gnt_s)
         3'b001: begin sel_addr_s = req_addr0; sel_data_s = req_data0; rr_ptr_d = 2'd1; end
         3'b010: begin sel_addr_s = req_addr1; sel_data_s = req_data1; rr_ptr_d = 2'd2; end
         3'b100: begin sel_addr_s = req_addr2; sel_data_s = req_data2; rr_ptr_d = 2'd0; end
         default: begin sel_addr_s = req_addr0; sel_data_s = req_data0; rr_ptr_d = rr_ptr_q; end
      endcase
      if (gnt_s != 3'b000) begin
         reg_W_addr_d = sel_addr_s;
         wdata_d      = sel_data_s;
         reg_we_d     = (sel_addr_s != {ADDR_W{1'b0}});
      end else begin
         reg_we_d     = 1'b0;
      end
   end

   // Scoreboard: the write-back clear happens first so a same-edge claim wins.
   always_comb begin
      claim_ok_s  = claim_valid && (claim_addr != {ADDR_W{1'b0}});
      clr_hit_s   = reg_we_q && (reg_W_addr_q == claim_addr);
      clr_mask_s  = reg_we_q   ? (ONE_HOT0 << reg_W_addr_q) : {NREG{1'b0}};
      set_mask_s  = claim_ok_s ? (ONE_HOT0 << claim_addr)   : {NREG{1'b0}};
      busy_vec_d  = ((busy_vec_q & ~clr_mask_s) | set_mask_s) & ~ONE_HOT0;
      claim_err_d = claim_ok_s && busy_vec_q[claim_addr] && !clr_hit_s;
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         rr_ptr_q     <= 2'd0;
         reg_W_addr_q <= {ADDR_W{1'b0}};
         wdata_q      <= {DATA_W{1'b0}};
         reg_we_q     <= 1'b0;
         busy_vec_q   <= {NREG{1'b0}};
         claim_err_q  <= 1'b0;
      end else begin
         rr_ptr_q     <= rr_ptr_d;
         reg_W_addr_q <= reg_W_addr_d;
         wdata_q      <= wdata_d;
         reg_we_q     <= reg_we_d;
         busy_vec_q   <= busy_vec_d;
         claim_err_q  <= claim_err_d;
      end
   end

   assign gnt        = gnt_s;
   assign reg_W_addr = reg_W_addr_q;
   assign wdata      = wdata_q;
   assign reg_we     = reg_we_q;
   assign busy_vec   = busy_vec_q;
   assign claim_err  = claim_err_q;
   assign busy_A     = busy_vec_q[chk_addr_A];
   assign busy_B     = busy_vec_q[chk_addr_B];

endmodule

// File: tb/tb_regs_wb_arbiter.sv
// Scoreboard bench for regs_wb_arbiter: stimulus queues expected grants, writes and
// error pulses; a negedge monitor pops and compares whenever the DUT presents one.
module tb_regs_wb_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  req;
   logic [4:0]  req_addr0, req_addr1, req_addr2;
   logic [31:0] req_data0, req_data1, req_data2;
   logic [2:0]  gnt;
   logic [4:0]  reg_W_addr;
   logic [31:0] wdata;
   logic        reg_we;
   logic        claim_valid;
   logic [4:0]  claim_addr, chk_addr_A, chk_addr_B;
   logic        busy_A, busy_B;
   logic [31:0] busy_vec;
   logic        claim_err;

   int n_cmp  = 0;
   int n_fail = 0;
   int cyc    = 0;

   logic [2:0]  gnt_q[$];
   logic [36:0] wr_q[$];
   int          err_q[$];

   regs_wb_arbiter #(.ADDR_W(5), .DATA_W(32)) dut (
      .clk(clk), .rst(rst), .req(req),
      .req_addr0(req_addr0), .req_addr1(req_addr1), .req_addr2(req_addr2),
      .req_data0(req_data0), .req_data1(req_data1), .req_data2(req_data2),
      .gnt(gnt), .reg_W_addr(reg_W_addr), .wdata(wdata), .reg_we(reg_we),
      .claim_valid(claim_valid), .claim_addr(claim_addr),
      .chk_addr_A(chk_addr_A), .chk_addr_B(chk_addr_B),
      .busy_A(busy_A), .busy_B(busy_B), .busy_vec(busy_vec), .claim_err(claim_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every grant, write and error pulse must match the head of its queue.
   always @(negedge clk) begin
      if (gnt !== 3'b000) begin
         if (gnt_q.size() == 0) chk("gnt_unexpected", {61'd0, gnt}, 64'd0);
         else chk("gnt", {61'd0, gnt}, {61'd0, gnt_q.pop_front()});
      end
      if (reg_we === 1'b1) begin
         if (wr_q.size() == 0) chk("write_unexpected", {27'd0, reg_W_addr, wdata}, 64'd0);
         else chk("write", {27'd0, reg_W_addr, wdata}, {27'd0, wr_q.pop_front()});
      end
      if (claim_err === 1'b1) begin
         if (err_q.size() == 0) chk("claim_err_unexpected", 64'(cyc), 64'd0);
         else chk("claim_err_cycle", 64'(cyc), 64'(err_q.pop_front()));
      end
   end

   initial begin
      rst = 1'b0; req = 3'b111;
      req_addr0 = 5'd1; req_addr1 = 5'd2; req_addr2 = 5'd3;
      req_data0 = 32'hA000_0001; req_data1 = 32'hB000_0002; req_data2 = 32'hC000_0003;
      claim_valid = 1'b0; claim_addr = 5'd0; chk_addr_A = 5'd0; chk_addr_B = 5'd0;

      // Reset held for two edges with all sources requesting.
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("rst_gnt", {61'd0, gnt}, 64'd0);
         chk("rst_reg_we", {63'd0, reg_we}, 64'd0);
         chk("rst_busy_vec", {32'd0, busy_vec}, 64'd0);
         chk("rst_claim_err", {63'd0, claim_err}, 64'd0);
      end
      tick();
      rst = 1'b1;

      // Round-robin across all three sources.
      for (int i = 0; i < 6; i++) begin
         case (i % 3)
            0: begin gnt_q.push_back(3'b001); wr_q.push_back({5'd1, 32'hA000_0001}); end
            1: begin gnt_q.push_back(3'b010); wr_q.push_back({5'd2, 32'hB000_0002}); end
            default: begin gnt_q.push_back(3'b100); wr_q.push_back({5'd3, 32'hC000_0003}); end
         endcase
         tick();
      end

      // Skip idle source: pointer moves to 1 after an ALU grant, then req=101.
      req = 3'b001; gnt_q.push_back(3'b001); wr_q.push_back({5'd1, 32'hA000_0001});
      tick();
      req = 3'b101; gnt_q.push_back(3'b100); wr_q.push_back({5'd3, 32'hC000_0003});
      tick();
      gnt_q.push_back(3'b001); wr_q.push_back({5'd1, 32'hA000_0001});
      tick();
      req = 3'b000;
      tick();

      // Scoreboard lifecycle on r5 (pointer is now 1, so the load unit wins).
      claim_valid = 1'b1; claim_addr = 5'd5; chk_addr_A = 5'd5; chk_addr_B = 5'd3;
      @(negedge clk);
      chk("busy_A_before_claim", {63'd0, busy_A}, 64'd0);
      tick();
      claim_valid = 1'b0;
      req = 3'b010; req_addr1 = 5'd5; req_data1 = 32'hDEAD_BEEF;
      gnt_q.push_back(3'b010); wr_q.push_back({5'd5, 32'hDEAD_BEEF});
      @(negedge clk);
      chk("busy_A_after_claim", {63'd0, busy_A}, 64'd1);
      chk("busy_B_unclaimed", {63'd0, busy_B}, 64'd0);
      chk("busy_vec_r5", {32'd0, busy_vec}, 64'h20);
      tick();
      req = 3'b000;
      @(negedge clk);
      chk("busy_A_during_we", {63'd0, busy_A}, 64'd1);
      tick();
      @(negedge clk);
      chk("busy_A_cleared", {63'd0, busy_A}, 64'd0);
      chk("reg_we_idle", {63'd0, reg_we}, 64'd0);
      chk("wdata_hold", {32'd0, wdata}, 64'hDEAD_BEEF);
      tick();

      // Claim r7, write it back (pointer 2, only ALU requesting), re-claim on the clear edge.
      claim_valid = 1'b1; claim_addr = 5'd7;
      tick();
      claim_valid = 1'b0;
      req = 3'b001; req_addr0 = 5'd7; req_data0 = 32'h0000_0077;
      gnt_q.push_back(3'b001); wr_q.push_back({5'd7, 32'h0000_0077});
      tick();
      req = 3'b000;
      claim_valid = 1'b1; claim_addr = 5'd7;
      tick();
      @(negedge clk);
      chk("busy_vec7_claim_wins", {63'd0, busy_vec[7]}, 64'd1);
      chk("claim_err_same_edge", {63'd0, claim_err}, 64'd0);
      err_q.push_back(cyc + 1);
      tick();
      claim_valid = 1'b0;
      @(negedge clk);
      chk("claim_err_pulse", {63'd0, claim_err}, 64'd1);
      chk("busy_vec7_double", {63'd0, busy_vec[7]}, 64'd1);
      tick();
      @(negedge clk);
      chk("claim_err_one_cycle", {63'd0, claim_err}, 64'd0);
      tick();

      // Address zero: grant to r0 (pointer 1) and a claim of r0.
      req = 3'b010; req_addr1 = 5'd0; req_data1 = 32'h1234_5678;
      claim_valid = 1'b1; claim_addr = 5'd0; chk_addr_A = 5'd0;
      gnt_q.push_back(3'b010);
      tick();
      req = 3'b000; claim_valid = 1'b0;
      @(negedge clk);
      chk("r0_reg_we", {63'd0, reg_we}, 64'd0);
      chk("r0_busy_vec0", {63'd0, busy_vec[0]}, 64'd0);
      chk("r0_busy_A", {63'd0, busy_A}, 64'd0);
      chk("r0_claim_err", {63'd0, claim_err}, 64'd0);
      chk("r0_busy_vec", {32'd0, busy_vec}, 64'h80);
      tick();
      tick();

      chk("gnt_queue_drained", 64'(gnt_q.size()), 64'd0);
      chk("write_queue_drained", 64'(wr_q.size()), 64'd0);
      chk("err_queue_drained", 64'(err_q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
